// File: rtl/rdfifo_uart_tx_if.sv
// Read-side handshake between the SDRAM read FIFO and the UART return engine.
// The engine is the master: it issues rd_en and consumes fill level and data.
interface rdfifo_uart_tx_if #(
  parameter int FIFO_CNT_W = 10
);
  logic [FIFO_CNT_W-1:0] rd_fifo_num;
  logic [7:0]            rd_fifo_rd_data;
  logic                  rd_en;

  modport master (input rd_fifo_num, input rd_fifo_rd_data, output rd_en);
  modport slave  (output rd_fifo_num, output rd_fifo_rd_data, input rd_en);
endinterface

// File: rtl/rdfifo_uart_tx.sv
// Burst-paced FIFO-to-UART transmitter: waits for a full burst, then pops and frames bytes.
// Define PARITY_EN for 8E1 framing (extra even-parity bit); default build is 8N1.
module rdfifo_uart_tx #(
  parameter int UART_BPS   = 9600,
  parameter int CLK_FREQ   = 50_000_000,
  parameter int FIFO_CNT_W = 10
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [23:0]             burst_num,
  rdfifo_uart_tx_if.master        fifo,
  output logic                    rs232_tx,
  output logic                    tx_busy,
  output logic                    burst_done
);
  localparam int BAUD_MAX = CLK_FREQ / UART_BPS;
  localparam int CW       = (BAUD_MAX > 1) ? $clog2(BAUD_MAX) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_MAX - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_LATCH  = 3'd2;
  localparam logic [2:0] S_START  = 3'd3;
  localparam logic [2:0] S_DATA   = 3'd4;
`ifdef PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd5;
`endif
  localparam logic [2:0] S_STOP   = 3'd6;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] baud_q,  baud_d;
  logic [2:0]    bit_q,   bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q,    tx_d;
  logic          done_q,  done_d;
  logic [23:0]   len_q,   len_d;
  logic [23:0]   cnt_q,   cnt_d;
  logic          pop;

  logic [23:0] num_ext;
  logic        baud_end;
  logic [2:0]  bit_nxt;
  logic [23:0] cnt_nxt;

  assign num_ext  = 24'(fifo.rd_fifo_num);
  assign baud_end = (baud_q == BAUD_LAST);
  assign bit_nxt  = bit_q + 3'd1;
  assign cnt_nxt  = cnt_q + 24'd1;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    len_d   = len_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        // The burst_done cycle is itself IDLE; a new trigger waits one more cycle.
        if (!done_q && burst_num != 24'd0 && num_ext >= burst_num) begin
          state_d = S_FETCH;
          len_d   = burst_num;
          cnt_d   = 24'd0;
        end
      end
      S_FETCH: begin
        if (fifo.rd_fifo_num != '0) begin
          pop     = 1'b1;
          state_d = S_LATCH;
        end
      end
      S_LATCH: begin
        // FIFO q is valid this cycle; pre-load the start bit so the line is registered.
        shift_d = fifo.rd_fifo_rd_data;
        tx_d    = 1'b0;
        baud_d  = '0;
        state_d = S_START;
      end
      S_START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
`ifdef PARITY_EN
            tx_d    = ^shift_q;
            state_d = S_PARITY;
`else
            tx_d    = 1'b1;
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_nxt;
            tx_d  = shift_q[bit_nxt];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`ifdef PARITY_EN
      S_PARITY: begin
        if (baud_end) begin
          baud_d  = '0;
          tx_d    = 1'b1;
          state_d = S_STOP;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (baud_end) begin
          baud_d = '0;
          cnt_d  = cnt_nxt;
          if (cnt_nxt == len_q) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_FETCH;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
      len_q   <= 24'd0;
      cnt_q   <= 24'd0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

  assign fifo.rd_en = pop;
  assign rs232_tx   = tx_q;
  assign tx_busy    = (state_q != S_IDLE);
  assign burst_done = done_q;
endmodule

// File: tb/tb_rdfifo_uart_tx.sv
// Randomized bench for rdfifo_uart_tx: FIFO model, line decoder and in-order byte reference.
module tb_rdfifo_uart_tx;
  localparam int BAUD = 10;
`ifdef PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME_CYC = NBITS * BAUD;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic [23:0] burst_num = 24'd0;
  logic        rs232_tx, tx_busy, burst_done, rd_en;
  logic [7:0]  rd_data = 8'd0;
  logic        ovr_en = 1'b0;
  logic [9:0]  ovr_val = 10'd0;

  int   n_tests = 0, n_fail = 0;
  int   cyc = 0;
  int   wp = 0, rp = 0;
  logic [7:0] mem [0:1023];
  logic [7:0] model_q [$];

  int   rd_cnt = 0, done_cnt = 0;
  int   done_t [$];
  logic [7:0] rx_byte [$];
  logic       rx_ok [$];
  int         rx_t0 [$];
  int         rx_rd = 0;

  rdfifo_uart_tx_if #(.FIFO_CNT_W(10)) bus ();

  assign bus.rd_fifo_num     = ovr_en ? ovr_val : 10'(wp - rp);
  assign bus.rd_fifo_rd_data = rd_data;
  assign rd_en               = bus.rd_en;

  rdfifo_uart_tx #(.UART_BPS(100_000), .CLK_FREQ(1_000_000), .FIFO_CNT_W(10)) dut (
    .clk(clk), .rstn(rstn), .burst_num(burst_num), .fifo(bus.master),
    .rs232_tx(rs232_tx), .tx_busy(tx_busy), .burst_done(burst_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Normal-mode FIFO: q valid the cycle after rd_en.
  always @(posedge clk) if (rd_en) begin
    rd_data <= mem[rp % 1024];
    rp      <= rp + 1;
  end

  always @(negedge clk) begin
    if (rd_en)      rd_cnt <= rd_cnt + 1;
    if (burst_done) begin
      done_cnt <= done_cnt + 1;
      done_t.push_back(cyc);
    end
  end

  // Line decoder: samples every cycle, each bit must hold for BAUD cycles.
  initial begin
    logic prev, ok, aborted;
    logic [NBITS-1:0] bits;
    int t0;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!rstn) prev = 1'b1;
      else if (prev && rs232_tx === 1'b0) begin
        t0 = cyc; ok = 1'b1; aborted = 1'b0; bits = '0;
        for (int b = 0; b < NBITS && !aborted; b++)
          for (int s = 0; s < BAUD && !aborted; s++) begin
            if (!(b == 0 && s == 0)) @(negedge clk);
            if (!rstn) aborted = 1'b1;
            else if (s == 0) bits[b] = rs232_tx;
            else if (rs232_tx !== bits[b]) ok = 1'b0;
          end
        if (!aborted) begin
          if (bits[0] !== 1'b0 || bits[NBITS-1] !== 1'b1) ok = 1'b0;
`ifdef PARITY_EN
          if (bits[9] !== ^bits[8:1]) ok = 1'b0;
`endif
          rx_byte.push_back(bits[8:1]);
          rx_ok.push_back(ok);
          rx_t0.push_back(t0);
        end
        prev = aborted ? 1'b1 : rs232_tx;
      end else prev = rs232_tx;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    mem[wp % 1024] = b;
    wp++;
    model_q.push_back(b);
  endtask

  task automatic wait_done(input int budget);
    int d0 = done_cnt;
    for (int i = 0; i < budget && done_cnt == d0; i++) @(posedge clk);
    #1;
    check("done_seen", done_cnt > d0, 1);
  endtask

  task automatic wait_rd(input int r0, input int budget);
    for (int i = 0; i < budget && rd_cnt == r0; i++) @(posedge clk);
    #1;
    check("rd_seen", rd_cnt > r0, 1);
  endtask

  // Compare the next n decoded frames against the FIFO-order reference.
  task automatic check_burst(input int n);
    logic [7:0] e;
    for (int i = 0; i < n; i++) begin
      e = (model_q.size() > 0) ? model_q.pop_front() : 8'hxx;
      if (rx_rd < rx_byte.size()) begin
        check("rx_byte", rx_byte[rx_rd], e);
        check("rx_frame", rx_ok[rx_rd], 1);
        rx_rd++;
      end else check("rx_missing", rx_byte.size(), rx_rd + 1);
    end
  endtask

  task automatic run_burst(input int n, input string tag);
    int r0, d0;
    r0 = rd_cnt; d0 = done_cnt;
    burst_num = 24'(n);
    wait_done(200 * n + 100);
    tick(5);
    check({tag, "_rd_pulses"}, rd_cnt - r0, n);
    check({tag, "_done_once"}, done_cnt - d0, 1);
    check_burst(n);
    if (done_t.size() > 0 && rx_t0.size() > 0)
      check({tag, "_frame_len"}, done_t[done_t.size()-1] - rx_t0[rx_t0.size()-1], FRAME_CYC);
    check({tag, "_busy_low"}, tx_busy, 0);
    check({tag, "_line_high"}, rs232_tx, 1);
    burst_num = 24'd0;
  endtask

  initial begin
    int r0, d0, n, f0;
    #3 rstn = 1'b0;
    #1;
    check("rst_tx", rs232_tx, 1);
    check("rst_rd_en", rd_en, 0);
    check("rst_busy", tx_busy, 0);
    check("rst_done", burst_done, 0);
    tick(2);
    rstn = 1'b1;
    tick(3);

    // Directed burst of three known bytes.
    push(8'h55); push(8'hA3); push(8'h01);
    run_burst(3, "t1");

    // Random bursts.
    for (int k = 0; k < 5; k++) begin
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) push(8'($urandom));
      run_burst(n, "rand");
    end

    // Insufficient fill level never starts; then exact trigger latency.
    push(8'($urandom)); push(8'($urandom));
    burst_num = 24'd3;
    r0 = rd_cnt; f0 = rx_byte.size();
    tick(1000);
    check("t2_no_rd", rd_cnt - r0, 0);
    check("t2_no_frame", rx_byte.size() - f0, 0);
    check("t2_line", rs232_tx, 1);
    check("t2_busy", tx_busy, 0);
    push(8'($urandom));
    @(negedge clk); check("t2_T_rd_en", rd_en, 0);
    @(negedge clk); check("t2_T1_rd_en", rd_en, 1);
    @(negedge clk); check("t2_T2_line", rs232_tx, 1);
    @(negedge clk); check("t2_T3_start", rs232_tx, 0);
    burst_num = 24'd0;
    wait_done(1000);
    tick(3);
    burst_num = 24'd0;
    check_burst(3);

    // Empty guard before the second fetch.
    push(8'($urandom)); push(8'($urandom));
    r0 = rd_cnt; d0 = done_cnt;
    burst_num = 24'd2;
    wait_rd(r0, 50);
    ovr_en = 1'b1; ovr_val = 10'd0;
    tick(200);
    check("t3_hold_rd", rd_cnt - r0, 1);
    check("t3_hold_busy", tx_busy, 1);
    check("t3_hold_line", rs232_tx, 1);
    check("t3_hold_done", done_cnt - d0, 0);
    ovr_val = 10'd1;
    wait_done(500);
    ovr_en = 1'b0;
    burst_num = 24'd0;
    tick(3);
    check("t3_rd", rd_cnt - r0, 2);
    check_burst(2);

    // Reset during a data bit of 0xF0.
    push(8'hF0); push(8'($urandom));
    d0 = done_cnt; f0 = rx_byte.size();
    burst_num = 24'd2;
    for (int i = 0; i < 50 && rs232_tx !== 1'b0; i++) tick(1);
    check("t4_started", rs232_tx, 0);
    tick(BAUD + 4 * BAUD + 5);
    rstn = 1'b0;
    #1;
    check("t4_rst_line", rs232_tx, 1);
    check("t4_rst_busy", tx_busy, 0);
    tick(1);
    rstn = 1'b1;
    void'(model_q.pop_front());
    tick(100);
    check("t4_no_done", done_cnt - d0, 0);
    check("t4_no_frame", rx_byte.size() - f0, 0);
    check("t4_idle", tx_busy, 0);
    push(8'($urandom));
    run_burst(2, "t4");

    // burst_num 0 and over-limit never start; mid-burst change ignored.
    push(8'($urandom)); push(8'($urandom)); push(8'($urandom));
    r0 = rd_cnt;
    burst_num = 24'd0;
    tick(300);
    check("t5_zero_rd", rd_cnt - r0, 0);
    check("t5_zero_busy", tx_busy, 0);
    ovr_en = 1'b1; ovr_val = 10'd1023;
    burst_num = 24'd1024;
    tick(300);
    check("t5_big_rd", rd_cnt - r0, 0);
    check("t5_big_busy", tx_busy, 0);
    burst_num = 24'd0;
    ovr_en = 1'b0;
    tick(1);
    d0 = done_cnt;
    burst_num = 24'd3;
    wait_rd(r0, 50);
    burst_num = 24'd1;
    wait_done(1000);
    burst_num = 24'd0;
    tick(5);
    check("t5_rd", rd_cnt - r0, 3);
    check("t5_done", done_cnt - d0, 1);
    check_burst(3);
    check("frames_total", rx_byte.size(), rx_rd);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
